// File: rtl/bitrev_reorder_buf.sv
// Purpose : ping-pong reorder buffer turning bit-reversed FFT frames into natural order.
// Latency : first natural-order sample valid the cycle after the last input of a frame.
// Backpr. : in_ready low while the write bank is still full; outputs held while !out_ready.
//
// Ports:
//   clk, rst_n                      clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready/in_data       bit-reversed sample stream in
//   out_valid/out_ready/out_data    natural-order sample stream out
//   out_index                       natural-order index of out_data
//   out_last                        final sample (index N-1) of a frame
//   frame_cnt                       frames delivered, only when FRAME_CNT_EN is defined
//
// Build option: define FRAME_CNT_EN to add the 16-bit wrapping frame_cnt output.
module bitrev_reorder_buf #(
    parameter int N     = 8,
    parameter int LOG2N = 3,
    parameter int DW    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic [LOG2N-1:0] out_index,
    output logic             out_last
`ifdef FRAME_CNT_EN
    ,
    output logic [15:0]      frame_cnt
`endif
);

    localparam logic [LOG2N-1:0] CNT_LAST = LOG2N'(N - 1);

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = v[LOG2N-1-i];
        end
        return r;
    endfunction

    // Sample storage: not reset, only ever read while its full flag is set.
    logic [DW-1:0]    bank_q [2][N];

    logic [1:0]       full_q,    full_d;
    logic             wr_bank_q, wr_bank_d;
    logic [LOG2N-1:0] wr_cnt_q,  wr_cnt_d;
    logic             rd_bank_q, rd_bank_d;
    logic [LOG2N-1:0] rd_cnt_q,  rd_cnt_d;

    logic             wr_acc;
    logic             rd_acc;

    assign in_ready  = !full_q[wr_bank_q];
    assign out_valid = full_q[rd_bank_q];
    // Gated so the output reads as zero out of reset, before any bank holds data.
    assign out_data  = out_valid ? bank_q[rd_bank_q][rd_cnt_q] : '0;
    assign out_index = rd_cnt_q;
    assign out_last  = out_valid && (rd_cnt_q == CNT_LAST);

    assign wr_acc = in_valid && in_ready;
    assign rd_acc = out_valid && out_ready;

    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        wr_cnt_d  = wr_cnt_q;
        rd_bank_d = rd_bank_q;
        rd_cnt_d  = rd_cnt_q;

        if (wr_acc) begin
            wr_cnt_d = wr_cnt_q + LOG2N'(1);
            if (wr_cnt_q == CNT_LAST) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
            end
        end

        // A write needs its bank empty and a read needs its bank full, so a
        // simultaneous set and clear always land on different banks.
        if (rd_acc) begin
            rd_cnt_d = rd_cnt_q + LOG2N'(1);
            if (rd_cnt_q == CNT_LAST) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = !rd_bank_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            rd_bank_q <= 1'b0;
            rd_cnt_q  <= '0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_bank_q <= rd_bank_d;
            rd_cnt_q  <= rd_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            bank_q[wr_bank_q][bitrev(wr_cnt_q)] <= in_data;
        end
    end

`ifdef FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (rd_acc && out_last) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_bitrev_reorder_buf.sv
module tb_bitrev_reorder_buf;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [2:0] out_index;
    logic       out_last;
`ifdef FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    bitrev_reorder_buf #(.N(8), .LOG2N(3), .DW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last)
`ifdef FRAME_CNT_EN
        ,
        .frame_cnt (frame_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] br3(input logic [2:0] k);
        return {k[0], k[1], k[2]};
    endfunction

    // Reference model state: frame f carries value f*8+j at natural index j.
    int         in_f = 0;
    int         in_k = 0;
    int         out_j = 0;
    int         out_frames = 0;
    logic [7:0] exp_q[$];

    // Samples taken by drive() just before the active edge.
    logic       s_ir, s_ov, s_ol, s_acc_in, s_acc_out;
    logic [7:0] s_od;
    logic [2:0] s_oi;

    // Applies one cycle of stimulus at posedge+1, samples at posedge+2,
    // scoreboards any output handshake, then returns at the next posedge+1.
    task automatic drive(input logic iv, input logic ordy);
        logic [7:0] e;
        in_valid  = iv;
        in_data   = 8'(in_f * 8 + int'(br3(3'(in_k))));
        out_ready = ordy;
        #1;
        s_ir = in_ready; s_ov = out_valid; s_od = out_data; s_oi = out_index; s_ol = out_last;
        s_acc_in  = in_valid && in_ready;
        s_acc_out = out_valid && out_ready;
        if (s_acc_out) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("sb_data", 32'(out_data), 32'(e));
            end
            check("sb_index", 32'(out_index), 32'(out_j));
            check("sb_last", 32'(out_last), 32'(out_j == 7));
            out_j++;
            if (out_j == 8) begin
                out_j = 0;
                out_frames++;
            end
        end
        if (s_acc_in) begin
            in_k++;
            if (in_k == 8) begin
                for (int j = 0; j < 8; j++) exp_q.push_back(8'(in_f * 8 + j));
                in_k = 0;
                in_f++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        in_k = 0; out_j = 0; out_frames = 0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic       iv;
        logic [7:0] idat;
        logic       ordy;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_od;
        logic [2:0] e_oi;
        logic       e_ol;
    } vec_t;

    vec_t       tbl[17];
    logic [7:0] fin[8];

    initial begin
        int cyc, first_out, last_out, n_out, drops, n_acc, guard, tgt;

        fin = '{8'h00, 8'h40, 8'h20, 8'h60, 8'h10, 8'h50, 8'h30, 8'h70};
        for (int i = 0; i < 8; i++)
            tbl[i] = '{iv: 1'b1, idat: fin[i], ordy: 1'b1, e_ir: 1'b1, e_ov: 1'b0,
                       e_od: 8'h00, e_oi: 3'd0, e_ol: 1'b0};
        for (int j = 0; j < 8; j++)
            tbl[8 + j] = '{iv: 1'b0, idat: 8'h00, ordy: 1'b1, e_ir: 1'b1, e_ov: 1'b1,
                           e_od: 8'(j * 16), e_oi: 3'(j), e_ol: (j == 7)};
        tbl[16] = '{iv: 1'b0, idat: 8'h00, ordy: 1'b1, e_ir: 1'b1, e_ov: 1'b0,
                    e_od: 8'h00, e_oi: 3'd0, e_ol: 1'b0};

        // Reset state
        do_reset();
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_index", 32'(out_index), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        @(posedge clk);
        #1;

        // Single frame, table driven
        for (int i = 0; i < 17; i++) begin
            in_valid  = tbl[i].iv;
            in_data   = tbl[i].idat;
            out_ready = tbl[i].ordy;
            #1;
            check($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_ir));
            check($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            check($sformatf("tbl%0d_out_data", i), 32'(out_data), 32'(tbl[i].e_od));
            check($sformatf("tbl%0d_out_index", i), 32'(out_index), 32'(tbl[i].e_oi));
            check($sformatf("tbl%0d_out_last", i), 32'(out_last), 32'(tbl[i].e_ol));
            @(posedge clk);
            #1;
        end

        // Back-to-back: three frames with both sides always ready
        do_reset();
        in_f = 0;
        first_out = -1; last_out = -1; n_out = 0; drops = 0;
        for (cyc = 0; cyc < 60 && out_frames < 3; cyc++) begin
            drive(in_f < 3, 1'b1);
            if (in_valid && !s_ir) drops++;
            if (s_acc_out) begin
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                n_out++;
            end
        end
        check("b2b_frames", 32'(out_frames), 32'd3);
        check("b2b_in_ready_drops", 32'(drops), 32'd0);
        check("b2b_first_out_cycle", 32'(first_out), 32'd8);
        check("b2b_out_count", 32'(n_out), 32'd24);
        check("b2b_no_gaps", 32'(last_out - first_out), 32'd23);
`ifdef FRAME_CNT_EN
        check("frame_cnt_3", 32'(frame_cnt), 32'd3);
        force dut.frame_cnt_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.frame_cnt_q;
        tgt = out_frames + 1;
        for (guard = 0; guard < 40 && out_frames < tgt; guard++) drive(in_f < 4, 1'b1);
        check("frame_cnt_wrap", 32'(frame_cnt), 32'd0);
`endif

        // Stall: two frames written with the reader blocked
        do_reset();
        n_acc = 0;
        for (guard = 0; guard < 40 && n_acc < 16; guard++) begin
            drive(1'b1, 1'b0);
            if (s_acc_in) n_acc++;
        end
        check("stall_accepts", 32'(n_acc), 32'd16);
        for (int h = 0; h < 3; h++) begin
            drive(1'b1, 1'b0);
            check("stall_in_ready", 32'(s_ir), 32'd0);
            check("stall_out_valid", 32'(s_ov), 32'd1);
            check("stall_hold_data", 32'(s_od), 32'(exp_q[0]));
            check("stall_hold_index", 32'(s_oi), 32'd0);
        end
        for (int d = 0; d < 8; d++) begin
            drive(1'b0, 1'b1);
            check("drain_in_ready_low", 32'(s_ir), 32'd0);
        end
        drive(1'b0, 1'b0);
        check("drain_in_ready_back", 32'(s_ir), 32'd1);

        // Reset in the middle of a frame
        do_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'd0);
        check("midrst_out_index", 32'(out_index), 32'd0);
        check("midrst_out_last", 32'(out_last), 32'd0);
        in_k = 0; out_j = 0; out_frames = 0;
        exp_q.delete();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tgt = in_f + 1;
        for (guard = 0; guard < 40 && out_frames < 1; guard++) drive(in_f < tgt, 1'b1);
        check("midrst_frame_out", 32'(out_frames), 32'd1);

        // Random valid/ready over 50 frames
        do_reset();
        tgt = in_f + 50;
        for (guard = 0; guard < 4000 && out_frames < 50; guard++)
            drive((in_f < tgt) && ($urandom_range(0, 1) == 1), $urandom_range(0, 3) != 0);
        check("rand_frames", 32'(out_frames), 32'd50);
        check("rand_leftover", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
